// File: rtl/exception_ctrl_if.sv
// Purpose : bundles the decoder-side event inputs and the exception controller's outputs.
// Latency : n/a (signal bundle only).
// Backpressure: none; ExtIRQ is a level held by its source until ExtIAck.
//
// Ports (slave = exception_ctrl view):
//   in : PC_in[63:0], NotAnInstr, ERet, ExtIRQ, EStatus_in[3:0]
//   out: EProc, ExcVector[63:0], ELR[63:0], ESR[3:0], ExtIAck, InHandler,
//        DoubleFault, ExcCount[7:0]
interface exception_ctrl_if;
  logic [63:0] PC_in;
  logic        NotAnInstr;
  logic        ERet;
  logic        ExtIRQ;
  logic [3:0]  EStatus_in;

  logic        EProc;
  logic [63:0] ExcVector;
  logic [63:0] ELR;
  logic [3:0]  ESR;
  logic        ExtIAck;
  logic        InHandler;
  logic        DoubleFault;
  logic [7:0]  ExcCount;

  // Decoder / core side: drives events, observes redirect and status.
  modport master (
    output PC_in, NotAnInstr, ERet, ExtIRQ, EStatus_in,
    input  EProc, ExcVector, ELR, ESR, ExtIAck, InHandler, DoubleFault, ExcCount
  );

  // Exception controller side.
  modport slave (
    input  PC_in, NotAnInstr, ERet, ExtIRQ, EStatus_in,
    output EProc, ExcVector, ELR, ESR, ExtIAck, InHandler, DoubleFault, ExcCount
  );
endinterface

// File: rtl/exception_ctrl.sv
// Purpose : takes undefined-opcode, illegal-ERET and external-IRQ events and redirects to the handler.
// Latency : event seen in RUN -> EProc/ExtIAck pulse in the next cycle (ENTER), then HANDLER.
// Backpressure: none; IRQ stays pending (unacked) while in ENTER/HANDLER until taken from RUN.
//
// Ports:
//   clk, reset   : single clock, synchronous active-high reset
//   bus (slave)  : event inputs from decode; EProc/ExtIAck/InHandler decoded from state,
//                  ELR/ESR/ExcCount/DoubleFault registered, ExcVector = VECTOR_ADDR
module exception_ctrl #(
  parameter logic [63:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8
) (
  input  logic clk,
  input  logic reset,
  exception_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, ENTER, HANDLER} state_t;

  state_t      state, state_nxt;
  logic [63:0] elr, elr_nxt;
  logic [3:0]  esr, esr_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        dfault, dfault_nxt;
  logic        irq_taken, irq_taken_nxt;   // remembers whether ENTER must also ack the IRQ

  logic        take;
  logic        take_irq;
  logic [3:0]  take_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      elr       <= '0;
      esr       <= '0;
      cnt       <= '0;
      dfault    <= 1'b0;
      irq_taken <= 1'b0;
    end else begin
      state     <= state_nxt;
      elr       <= elr_nxt;
      esr       <= esr_nxt;
      cnt       <= cnt_nxt;
      dfault    <= dfault_nxt;
      irq_taken <= irq_taken_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    elr_nxt       = elr;
    esr_nxt       = esr;
    cnt_nxt       = cnt;
    dfault_nxt    = dfault;
    irq_taken_nxt = irq_taken;
    take          = 1'b0;
    take_irq      = 1'b0;
    take_code     = 4'b0000;

    case (state)
      RUN: begin
        // Priority: undefined opcode, then ERET (illegal outside the handler), then IRQ.
        if (bus.NotAnInstr) begin
          take      = 1'b1;
          take_code = bus.EStatus_in;
        end else if (bus.ERet) begin
          take      = 1'b1;
          take_code = 4'b0100;
        end else if (bus.ExtIRQ) begin
          take      = 1'b1;
          take_irq  = 1'b1;
          take_code = 4'b0001;
        end
        if (take) begin
          state_nxt     = ENTER;
          elr_nxt       = bus.PC_in;
          esr_nxt       = take_code;
          irq_taken_nxt = take_irq;
          if (cnt != 8'hFF) cnt_nxt = cnt + 8'd1;
        end
      end
      ENTER: begin
        // Redirect cycle; events are not looked at.
        state_nxt = HANDLER;
      end
      HANDLER: begin
        // A fault inside the handler only flags; it never re-enters or returns.
        if (bus.NotAnInstr) dfault_nxt = 1'b1;
        else if (bus.ERet)  state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign bus.EProc       = (state == ENTER);
  assign bus.ExtIAck     = (state == ENTER) && irq_taken;
  assign bus.InHandler   = (state != RUN);
  assign bus.ExcVector   = VECTOR_ADDR;
  assign bus.ELR         = elr;
  assign bus.ESR         = esr;
  assign bus.ExcCount    = cnt;
  assign bus.DoubleFault = dfault;

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Parameters
REQ-001 SHALL have parameter VECTOR_ADDR, default 64'h0000_0000_0000_00D8, meaning the exception handler entry address driven on ExcVector.

Interface
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port PC_in, input, 64, address of the instruction in decode this cycle.
REQ-005 SHALL have port NotAnInstr, input, 1, decoder flag: undefined opcode this cycle.
REQ-006 SHALL have port ERet, input, 1, decoder flag: ERET in decode this cycle.
REQ-007 SHALL have port ExtIRQ, input, 1, level interrupt request; the source holds it until ExtIAck.
REQ-008 SHALL have port EStatus_in, input, 4, decoder status code (4'b0010 for undefined opcode).
REQ-009 SHALL have port EProc, output, 1, one-cycle PC redirect to ExcVector.
REQ-010 SHALL have port ExcVector, output, 64, constant VECTOR_ADDR.
REQ-011 SHALL have port ELR, output, 64, exception link register (return address).
REQ-012 SHALL have port ESR, output, 4, exception syndrome register.
REQ-013 SHALL have port ExtIAck, output, 1, one-cycle interrupt acknowledge.
REQ-014 SHALL have port InHandler, output, 1, high while in ENTER or HANDLER.
REQ-015 SHALL have port DoubleFault, output, 1, sticky flag for a fault raised inside the handler.
REQ-016 SHALL have port ExcCount, output, 8, number of exceptions taken, saturating.

Function
REQ-017 SHALL implement three states: RUN, ENTER, HANDLER.
REQ-018 In RUN, an event SHALL be taken at the clock edge ending the cycle in which it is seen; priority order: NotAnInstr, then ERet (illegal outside handler), then ExtIRQ.
REQ-019 Taking an event SHALL load ELR with PC_in, load ESR, move to ENTER, and increment ExcCount unless it is already 8'hFF.
REQ-020 ESR load values SHALL be: EStatus_in for NotAnInstr; 4'b0100 for illegal ERet; 4'b0001 for ExtIRQ.
REQ-021 In ENTER, EProc SHALL be 1 for exactly one cycle; ExtIAck SHALL be 1 in that same cycle only if the taken event was ExtIRQ; the next state SHALL be HANDLER unconditionally.
REQ-022 In HANDLER, ERet SHALL cause a transition to RUN at the next edge, with ELR and ESR unchanged.
REQ-023 In HANDLER, NotAnInstr SHALL set DoubleFault at the next edge; ELR, ESR, state and ExcCount SHALL stay unchanged.
REQ-024 In HANDLER, ExtIRQ SHALL be ignored and left pending (no ack); if it is still high in the first RUN cycle after return, it SHALL be taken then.
REQ-025 Simultaneous NotAnInstr and ExtIRQ in RUN SHALL take NotAnInstr only; ExtIRQ stays unacked.
REQ-026 In ENTER, all event inputs SHALL be ignored.
REQ-027 EProc, ExtIAck and InHandler SHALL be decoded from registered state only, with no combinational path from any input.
REQ-028 In RUN with no event, all registers SHALL hold their values.

Reset
REQ-029 With reset=1 at an edge: state RUN; ELR 0; ESR 0; ExcCount 0; DoubleFault 0. Reset SHALL take priority over every event.
REQ-030 During and after reset: EProc 0, ExtIAck 0, InHandler 0.
REQ-031 Reset asserted while in ENTER SHALL suppress the EProc/ExtIAck pulse that would otherwise follow.

Verification
REQ-032 Undefined opcode: PC_in=0x40, NotAnInstr=1, EStatus_in=4'b0010 for 1 cycle -> next cycle EProc=1, ELR=0x40, ESR=2, ExcCount=1; following cycle InHandler=1, EProc=0.
REQ-033 IRQ round trip: ExtIRQ=1 held from RUN at PC_in=0x80 -> ExtIAck=1 in the same cycle as EProc, ESR=1; drop ExtIRQ; ERet in HANDLER -> RUN next cycle, ELR still 0x80.
REQ-034 Simultaneous: NotAnInstr=1 and ExtIRQ=1 at PC_in=0x10 -> ESR=2, no ExtIAck; ExtIRQ held, ERet -> IRQ taken in the first RUN cycle, ESR=1, ExcCount=2.
REQ-035 Faults in handler: NotAnInstr in HANDLER -> DoubleFault=1, ELR/ESR/ExcCount unchanged; ERet in RUN at PC_in=0x20 -> ESR=4'b0100, ELR=0x20.
REQ-036 Saturation and reset: take 256 exceptions -> ExcCount=8'hFF, not wrapped; reset in ENTER -> no EProc pulse, all outputs 0.
